fixed_to_float_packer: RTL and testbench



---
 rtl/cordic_pkg.sv | 10 +
 rtl/fixed_to_float_packer_lzc32.sv | 17 +
 rtl/fixed_to_float_packer.sv | 109 ++++++++++
 tb/tb_fixed_to_float_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Constants shared by the CORDIC core and its fixed/float converters.
// Fixed-point words are Q(32-FRACTIONAL_BITS).FRACTIONAL_BITS two's complement.
package cordic_pkg;

  localparam int FRAC_BITS_DEFAULT = 30;
  localparam int FP32_EXP_BIAS     = 127;
  localparam int FP32_MANT_W       = 23;
  localparam int FP32_EXP_W        = 8;

endpackage

// File: rtl/fixed_to_float_packer_lzc32.sv
// lzc32: combinational position of the most significant set bit of a 32-bit word.
// p is don't-care (driven 0) when zero is set.
module lzc32 (
  input  logic [31:0] mag,
  output logic [4:0]  p,
  output logic        zero
);

  always_comb begin
    p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    zero = (mag == 32'd0);
  end

endmodule

// File: rtl/fixed_to_float_packer.sv
// Three-stage fixed-point to float32 converter: |x|, leading-one detect, normalise/round/pack.
// One global enable stalls the whole pipe whenever the output is held.
module fixed_to_float_packer
  import cordic_pkg::*;
#(
  parameter int FRACTIONAL_BITS = FRAC_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic        en;
  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d;
  logic [31:0] s1_mag_q, s1_mag_d, s2_mag_q, s2_mag_d;
  logic [4:0]  s2_p_q, s2_p_d;
  logic        s2_zero_q, s2_zero_d;
  logic [31:0] out_data_q, out_data_d;

  logic [4:0]  lzc_p;
  logic        lzc_zero;
  logic [30:0] aligned;
  logic [22:0] mant;
  logic        guard, sticky, round_up;
  logic [23:0] mant_r;
  logic [FP32_EXP_W-1:0] exp_base, exp_fin;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_data  = out_data_q;

  lzc32 u_lzc32 (
    .mag  (s1_mag_q),
    .p    (lzc_p),
    .zero (lzc_zero)
  );

  // Normalise: bit p lands on the (dropped) hidden-one position, bit 31.
  always_comb begin
    aligned  = 31'(s2_mag_q << (5'd31 - s2_p_q));
    mant     = aligned[30:8];
    guard    = aligned[7];
    sticky   = |aligned[6:0];
    round_up = guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    // Exponent always lands in 1..254, so the low 8 bits of the 9-bit sum are exact.
    exp_base = FP32_EXP_W'(FP32_EXP_BIAS) + {3'd0, s2_p_q} - FP32_EXP_W'(FRACTIONAL_BITS);
    exp_fin  = mant_r[23] ? exp_base + 8'd1 : exp_base;
  end

  always_comb begin
    v1_d       = v1_q;
    v2_d       = v2_q;
    v3_d       = v3_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s2_sign_d  = s2_sign_q;
    s2_mag_d   = s2_mag_q;
    s2_p_d     = s2_p_q;
    s2_zero_d  = s2_zero_q;
    out_data_d = out_data_q;
    if (en) begin
      v1_d       = in_valid;
      s1_sign_d  = in_data[31];
      s1_mag_d   = in_data[31] ? (~in_data + 32'd1) : in_data;
      v2_d       = v1_q;
      s2_sign_d  = s1_sign_q;
      s2_mag_d   = s1_mag_q;
      s2_p_d     = lzc_p;
      s2_zero_d  = lzc_zero;
      v3_d       = v2_q;
      out_data_d = s2_zero_q ? 32'd0 : {s2_sign_q, exp_fin, mant_r[22:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= 32'd0;
      s2_sign_q  <= 1'b0;
      s2_mag_q   <= 32'd0;
      s2_p_q     <= 5'd0;
      s2_zero_q  <= 1'b0;
      out_data_q <= 32'd0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_sign_q  <= s2_sign_d;
      s2_mag_q   <= s2_mag_d;
      s2_p_q     <= s2_p_d;
      s2_zero_q  <= s2_zero_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fixed_to_float_packer.sv
// Scoreboard bench for fixed_to_float_packer: driver pushes expected floats on accept,
// monitor pops and compares on every output transfer.
module tb_fixed_to_float_packer;

  localparam int FB = 30;

  typedef struct {
    logic [31:0] data;
    int          acc_edge;
    logic [31:0] din;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          hold_q = 1'b0;
  logic [31:0] hold_data = 32'd0;

  fixed_to_float_packer #(.FRACTIONAL_BITS(FB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer arithmetic on the real value, round-half-even to 24 significant bits.
  function automatic logic [31:0] ref_f32(input logic [31:0] x);
    longint v, m, q, r, d, half;
    int     e, ex;
    logic   s;
    logic [7:0] ex8;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) q = m << (23 - e);
    else begin
      d = longint'(1) << (e - 23);
      q = m / d;
      r = m % d;
      half = d / 2;
      if (r > half || (r == half && q[0])) q++;
    end
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    ex = 127 + e - FB;
    ex8 = ex[7:0];
    return {s, ex8, q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (v && in_ready && !reset) begin
      e.data = ref_f32(d);
      e.acc_edge = cyc + 1;
      e.din = d;
      sb.push_back(e);
    end
  endtask

  // Monitor: sampled 2 time units after the falling edge, well away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      hold_q = 1'b0;
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (hold_q) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_data, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          check($sformatf("data_in_%08h", e.din), out_data, e.data);
          if (lat_chk) check("latency", 32'(cyc + 1 - e.acc_edge), 32'd3);
        end
      end
      hold_q = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 4))
      0: w = $urandom;
      1: w = $urandom_range(0, 255);
      2: w = 32'h4000_0000 | {24'd0, 1'b1, 7'd0} | ($urandom_range(0, 3) << 8);
      3: w = {1'b1, 31'($urandom)};
      default: w = $urandom >> $urandom_range(0, 31);
    endcase
    return w;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      drive(1'b0, 32'd0, 1'b1);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] dir_in [12];
    logic [31:0] dir_out[12];
    dir_in  = '{32'h4000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000,
                32'h0000_0001, 32'h7FFF_FFFF, 32'h4000_0040, 32'h4000_00C0,
                32'h4000_0041, 32'hFFFF_FFFF, 32'h2000_0000, 32'h0000_0003};
    dir_out = '{32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000,
                32'h3080_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0002,
                32'h3F80_0001, 32'hB080_0000, 32'h3F00_0000, 32'h3140_0000};

    // Reset state
    #3;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Hand-computed golden values also cross-check the reference model.
    for (int i = 0; i < 12; i++) check("ref_model_golden", ref_f32(dir_in[i]), dir_out[i]);

    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) drive(1'b1, dir_in[i], 1'b1);
    drain();

    // Back-to-back streaming, no stalls: each result exactly 3 edges after accept.
    for (int i = 0; i < 100; i++) drive(1'b1, rand_word(), 1'b1);
    drain();
    lat_chk = 1'b0;

    // Backpressure: fill pipe, hold out_ready low 5 cycles, then random toggling.
    for (int i = 0; i < 4; i++) drive(1'b1, rand_word(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rand_word(), 1'b0);
      check("full_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 2) != 0));
    drain();

    // Asynchronous reset mid-stream with the pipe full.
    for (int i = 0; i < 4; i++) drive(1'b1, rand_word(), 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_out_data", out_data, 32'd0);
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h4000_0000, 1'b1);
    drain();
    lat_chk = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
